// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier: radix-2 shift-add mantissa product, one bit per clock.
// Optional FP_MUL_SEQ_EARLY_EXIT_EN skips the shift-add loop for special/zero operands.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] res,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sign;
  logic [7:0]          r_ea, r_eb;
  logic [23:0]         r_mcand, r_mplier;
  logic [47:0]         r_acc;
  logic [4:0]          r_cnt;
  logic                r_busy, r_done, r_exc, r_ovf, r_unf;
  logic [31:0]         r_res;

  logic                w_accept, w_early;
  logic [24:0]         w_sum;
  logic                w_n, w_rnd, w_exc;
  logic [46:0]         w_pn;
  logic [23:0]         w_m24;
  logic [22:0]         w_frac;
  logic signed [9:0]   w_exp_base, w_exp_fin;
  logic [31:0]         w_res_nxt;
  logic                w_ovf_nxt, w_unf_nxt;

  // The done cycle blocks acceptance so back-to-back starts are spaced by one idle edge.
  assign w_accept = (r_state == S_IDLE) && start && !r_done;

`ifdef FP_MUL_SEQ_EARLY_EXIT_EN
  assign w_early = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
                   (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_early ? S_NORM : S_MULT;
      S_MULT: if (r_cnt == 5'd23) w_state_nxt = S_NORM;
      S_NORM: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Multiplicand is added into the upper half, then the whole accumulator shifts right.
  assign w_sum = {1'b0, r_acc[47:24]} + {1'b0, (r_mplier[0] ? r_mcand : 24'd0)};

  assign w_n        = r_acc[47];
  assign w_pn       = w_n ? r_acc[46:0] : {r_acc[45:0], 1'b0};
  assign w_rnd      = w_pn[23] & (|w_pn[22:0]);
  assign w_m24      = {1'b0, w_pn[46:24]} + {23'd0, w_rnd};
  assign w_exp_base = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127
                      + $signed({9'd0, w_n});
  assign w_exp_fin  = w_exp_base + (w_m24[23] ? 10'sd1 : 10'sd0);
  assign w_frac     = w_m24[23] ? 23'd0 : w_m24[22:0];
  assign w_exc      = (r_ea == 8'hFF) || (r_eb == 8'hFF);

  always_comb begin
    w_res_nxt = {r_sign, w_exp_fin[7:0], w_frac};
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (w_exc) begin
      w_res_nxt = 32'd0;
    end else if (r_acc == 48'd0) begin
      w_res_nxt = {r_sign, 31'd0};
    end else if (w_exp_fin >= 10'sd255) begin
      w_ovf_nxt = 1'b1;
      w_res_nxt = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_fin <= 10'sd0) begin
      w_unf_nxt = 1'b1;
      w_res_nxt = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_ea     <= 8'd0;
      r_eb     <= 8'd0;
      r_mcand  <= 24'd0;
      r_mplier <= 24'd0;
      r_acc    <= 48'd0;
      r_cnt    <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res    <= 32'd0;
      r_exc    <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign   <= a[31] ^ b[31];
            r_ea     <= a[30:23];
            r_eb     <= b[30:23];
            r_mcand  <= {(a[30:23] != 8'd0), a[22:0]};
            r_mplier <= {(b[30:23] != 8'd0), b[22:0]};
            r_acc    <= 48'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
          end
        end
        S_MULT: begin
          r_acc    <= {w_sum, r_acc[23:1]};
          r_mplier <= {1'b0, r_mplier[23:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        S_NORM: begin
          r_res  <= w_res_nxt;
          r_exc  <= w_exc;
          r_ovf  <= w_ovf_nxt;
          r_unf  <= w_unf_nxt;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign res       = r_res;
  assign exception = r_exc;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: expectations queued at stimulus, popped on done.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done, exception, overflow, underflow;
  logic [31:0] res;

  typedef struct {
    logic [31:0] res;
    logic        exc, ovf, unf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int FULL_LAT = 25;
`ifdef FP_MUL_SEQ_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 25;
`endif

  fp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .res(res),
    .exception(exception), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one operation, pushes its expectation, waits (bounded) for done and returns what was seen.
  task automatic drive_op(input logic [31:0] ia, input logic [31:0] ib, input exp_t e,
                          output int lat, output bit got, output logic busy_acc,
                          output logic [31:0] o_res, output logic [2:0] o_flags);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    a = $urandom; b = $urandom;
    lat = 0; got = 0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) got = 1;
    end
    o_res   = res;
    o_flags = {exception, overflow, underflow};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, res, exception, overflow, underflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, res, exception, overflow, underflow});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, res} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h required 0", {busy, done, res});
    end
  endtask

  task automatic test_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eres, input logic [2:0] eflags, input int elat);
    exp_t e, p;
    int lat; bit got; logic busy_acc; logic [31:0] o_res; logic [2:0] o_flags;
    e.res = eres; e.exc = eflags[2]; e.ovf = eflags[1]; e.unf = eflags[0];
    drive_op(ia, ib, e, lat, got, busy_acc, o_res, o_flags);
    n_checks++;
    if (busy_acc !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_accept: got %b required 1", name, busy_acc);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, lat);
      void'(sb.pop_front());
      return;
    end
    if (lat !== elat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
    end
    p = sb.pop_front();
    n_checks++;
    if (o_res !== p.res) begin
      n_fail++;
      $display("FAIL %s res: got %h required %h", name, o_res, p.res);
    end
    n_checks++;
    if (o_flags !== {p.exc, p.ovf, p.unf}) begin
      n_fail++;
      $display("FAIL %s flags(exc,ovf,unf): got %b required %b", name, o_flags, {p.exc, p.ovf, p.unf});
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_with_done: got %b required 0", name, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse_width: got %b required 0", name, done);
    end
  endtask

  task automatic test_normal();
    test_op("mul_6", 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, FULL_LAT);
    test_op("mul_2p25", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, FULL_LAT);
  endtask

  task automatic test_signed();
    test_op("signed", 32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000, FULL_LAT);
  endtask

  task automatic test_exceptions();
    test_op("exception", 32'h7F800000, 32'h3F800000, 32'h00000000, 3'b100, EARLY_LAT);
    test_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, FULL_LAT);
  endtask

  task automatic test_underflow_zero();
    test_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, FULL_LAT);
    test_op("neg_zero", 32'h80000000, 32'h40400000, 32'h80000000, 3'b000, EARLY_LAT);
  endtask

  task automatic test_back_to_back();
    exp_t e, p;
    int t[3];
    int nd, c, extra;
    e.res = 32'hC0400000; e.exc = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(e);
    nd = 0; c = 0;
    @(negedge clk);
    a = 32'hBFC00000; b = 32'h40000000; start = 1'b1;
    while (nd < 3 && c < 120) begin
      @(posedge clk); #1;
      c++;
      if (done === 1'b1) begin
        t[nd] = c;
        nd++;
        p = sb.pop_front();
        n_checks++;
        if (res !== p.res) begin
          n_fail++;
          $display("FAIL b2b_res%0d: got %h required %h", nd, res, p.res);
        end
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (nd !== 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 3", nd);
      while (sb.size() > 0) void'(sb.pop_front());
    end else begin
      if (t[0] !== 26) begin
        n_fail++;
        $display("FAIL b2b_first_latency: got %0d required 26", t[0]);
      end
      n_checks++;
      if (t[1] - t[0] !== 27 || t[2] - t[1] !== 27) begin
        n_fail++;
        $display("FAIL b2b_interval: got %0d,%0d required 27,27", t[1] - t[0], t[2] - t[1]);
      end
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL b2b_extra_done: got %0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, res, exception, overflow, underflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required 0", {busy, done, res, exception, overflow, underflow});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d active cycles required 0", seen);
    end
    test_op("after_reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, FULL_LAT);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_signed();
    test_back_to_back();
    test_exceptions();
    test_underflow_zero();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
